peb_mac_dispatch: RTL



---
 rtl/peb_mac_dispatch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/peb_mac_dispatch.sv
// Round-robin row dispatcher for the MAC array of one PEB: grants rows to idle MACs and tracks completions.
// Optional stall perf counter compiled only when ARB_PERF_CNT_EN is defined.
module peb_mac_dispatch #(
  parameter int unsigned NUM_MAC = 4,
  parameter int unsigned ROW_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PEB_Sta,
  input  logic [ROW_W-1:0]   PEB_RowNum,
  input  logic [1:0]         PEB_WeiCol,
  input  logic [NUM_MAC-1:0] MACARB_ReqHelp,
  output logic [NUM_MAC-1:0] ARBMAC_Rst,
  output logic [ROW_W-1:0]   ARBMAC_Row,
  output logic [1:0]         PEBMAC_WeiCol,
  output logic               ARBPEB_Busy,
  output logic               ARBPEB_Fnh,
  output logic [15:0]        ARBPEB_StallCnt
);

  localparam int unsigned PTR_W = $clog2(NUM_MAC);
  localparam int unsigned SUM_W = ROW_W + 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e             state_q;
  logic [NUM_MAC-1:0] mac_rst_q;
  logic [NUM_MAC-1:0] busy_q, busy_d;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   rownum_q;
  logic [ROW_W-1:0]   issued_q;
  logic [ROW_W-1:0]   done_cnt_q, done_cnt_d;
  logic [1:0]         weicol_q;
  logic               busy_out_q;
  logic               fnh_q;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_MAC-1:0] elig;
  logic [NUM_MAC-1:0] cmpl;
  logic [NUM_MAC-1:0] gnt_oh;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic               rows_left;
  logic               do_grant;
  logic [SUM_W-1:0]   done_sum;
  int                 scan_idx;

  // A MAC pulsed this cycle still shows ReqHelp, so it is neither eligible nor completing.
  assign cmpl      = busy_q & MACARB_ReqHelp & ~mac_rst_q;
  assign elig      = MACARB_ReqHelp & ~busy_q & ~mac_rst_q;
  assign rows_left = (issued_q < rownum_q);

  // First eligible MAC scanning upward from rr_ptr with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < int'(NUM_MAC); k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % int'(NUM_MAC);
      if (!gnt_found && elig[PTR_W'(scan_idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(scan_idx);
      end
    end
  end

  assign do_grant = (state_q == S_DISPATCH) && rows_left && gnt_found;
  assign gnt_oh   = do_grant ? (NUM_MAC'(1) << gnt_idx) : '0;
  assign busy_d   = (busy_q & ~cmpl) | gnt_oh;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (do_grant) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_MAC - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // Completion count saturates instead of wrapping.
  assign done_sum   = {1'b0, done_cnt_q} + SUM_W'($countones(cmpl));
  assign done_cnt_d = done_sum[ROW_W] ? '1 : done_sum[ROW_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mac_rst_q  <= '0;
      busy_q     <= '0;
      row_q      <= '0;
      rownum_q   <= '0;
      issued_q   <= '0;
      done_cnt_q <= '0;
      weicol_q   <= '0;
      busy_out_q <= 1'b0;
      fnh_q      <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      mac_rst_q  <= gnt_oh;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      done_cnt_q <= done_cnt_d;
      fnh_q      <= 1'b0;
      if (do_grant) begin
        row_q    <= issued_q;
        issued_q <= issued_q + ROW_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (PEB_Sta) begin
            rownum_q   <= PEB_RowNum;
            weicol_q   <= PEB_WeiCol;
            issued_q   <= '0;
            done_cnt_q <= '0;
            busy_out_q <= 1'b1;
            state_q    <= (PEB_RowNum == '0) ? S_DRAIN : S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (!rows_left) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((busy_q == '0) && (done_cnt_q == rownum_q)) begin
            state_q    <= S_DONE;
            busy_out_q <= 1'b0;
            fnh_q      <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Dispatch cycles with rows pending but no MAC to take one.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && PEB_Sta) begin
      stall_q <= '0;
    end else if ((state_q == S_DISPATCH) && rows_left && !gnt_found && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign ARBPEB_StallCnt = stall_q;
`else
  assign ARBPEB_StallCnt = '0;
`endif

  assign ARBMAC_Rst    = mac_rst_q;
  assign ARBMAC_Row    = row_q;
  assign PEBMAC_WeiCol = weicol_q;
  assign ARBPEB_Busy   = busy_out_q;
  assign ARBPEB_Fnh    = fnh_q;

endmodule
